// File: rtl/ones_count_decoder_pkg.sv
// Shared constants and types for the ones-count decoder. The encoder and its
// bench use the same word/code widths so both ends of the link agree.
package ones_count_decoder_pkg;

  // Output word width; legal codes are 0..W.
  localparam int W = 16;
  // Code width; 2**CW must exceed W so code W is representable.
  localparam int CW = 5;
  // Output buffer entries. The occupancy FSM below only covers two.
  localparam int DEPTH = 2;
  // Codes strictly above this value are out of range and flagged as errors.
  localparam int CODE_MAX = W;

  // Buffer occupancy. The encodings equal the entry count so the state
  // register can drive the count port directly.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // One buffered result: error flag alongside the thermometer word.
  typedef struct packed {
    logic         err;
    logic [W-1:0] word;
  } entry_t;

endpackage

// File: rtl/ones_count_decoder_therm_decode.sv
// Combinational code -> thermometer word. Bit k is set when k < code, so any
// code of W or more saturates to all ones; codes above W also raise err.
module ones_count_decoder_therm_decode
  import ones_count_decoder_pkg::*;
(
  input  logic [CW-1:0] i_code,
  output entry_t        o_entry
);

  logic [W-1:0] w_word;
  logic         w_err;

  // One comparator per output bit against its own bit index.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      localparam logic [CW-1:0] K = CW'(gi);
      assign w_word[gi] = (i_code > K);
    end
  endgenerate

  assign w_err = (i_code > CW'(CODE_MAX));

  // Pack the result into a buffer entry.
  always_comb begin
    o_entry      = '0;
    o_entry.word = w_word;
    o_entry.err  = w_err;
  end

endmodule

// File: rtl/ones_count_decoder.sv
// Ones-count decoder: accepts a count code with a valid/ready handshake,
// decodes it to a thermometer word and queues {err,word} in a two-entry
// circular buffer. The head entry drives the outputs straight from storage,
// so there is no combinational path from in_code to out_word.
module ones_count_decoder
  import ones_count_decoder_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [CW-1:0] in_code,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_word,
  output logic          out_err,
  input  logic          out_ready,
  output logic [1:0]    count
);

  occ_e   r_state;
  occ_e   w_state_next;
  entry_t r_mem [DEPTH];
  logic   r_wr_ptr;
  logic   r_rd_ptr;
  logic   w_push;
  logic   w_pop;
  entry_t w_dec;
  entry_t w_head;

  ones_count_decoder_therm_decode u_decode (
    .i_code  (in_code),
    .o_entry (w_dec)
  );

  // Handshake: a pop frees a slot in the same cycle, so a full buffer can
  // still accept when the consumer is draining.
  assign out_valid = (r_state != OCC_EMPTY);
  assign w_pop     = out_valid & out_ready;
  assign in_ready  = (r_state != OCC_FULL) | w_pop;
  assign w_push    = in_valid & in_ready;
  assign count     = r_state;

  assign w_head   = r_mem[r_rd_ptr];
  assign out_word = w_head.word;
  assign out_err  = w_head.err;

  // Occupancy state register; reset overrides any push or pop that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Occupancy next state: push&pop together leave the count unchanged.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      OCC_EMPTY: begin
        if (w_push) w_state_next = OCC_ONE;
      end
      OCC_ONE: begin
        if (w_push && !w_pop)      w_state_next = OCC_FULL;
        else if (w_pop && !w_push) w_state_next = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (w_pop && !w_push) w_state_next = OCC_ONE;
      end
      default: w_state_next = OCC_EMPTY;
    endcase
  end

  // Read/write pointers each toggle when their side of the buffer moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // Buffer storage; cleared on reset so the outputs are never X when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_dec;
    end
  end

endmodule

// File: tb/tb_ones_count_decoder.sv
// Directed bench for the ones-count decoder: reset state, streaming,
// back-pressure, push-while-full-with-pop, out-of-range codes, mid-stream
// reset and a round trip of every legal code back to its ones count.
module tb_ones_count_decoder;
  import ones_count_decoder_pkg::*;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [CW-1:0] in_code;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_word;
  logic          out_err;
  logic          out_ready;
  logic [1:0]    count;

  int errors = 0;
  int checks = 0;

  ones_count_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_err   (out_err),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Push one code with the given out_ready and return after the edge.
  task automatic push(input logic [CW-1:0] code, input logic rdy);
    in_valid  = 1'b1;
    in_code   = code;
    out_ready = rdy;
    tick();
  endtask

  initial begin
    logic [W-1:0] exp_word;

    reset = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // 1: reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_word", 32'(out_word), 32'h0000);
    chk("rst_err", 32'(out_err), 32'd0);

    // 2: streaming with consumer always ready
    push(5'd0, 1'b1);
    chk("s0_valid", 32'(out_valid), 32'd1);
    chk("s0_word", 32'(out_word), 32'h0000);
    chk("s0_count", 32'(count), 32'd1);
    push(5'd1, 1'b1);
    chk("s1_word", 32'(out_word), 32'h0001);
    chk("s1_count", 32'(count), 32'd1);
    push(5'd5, 1'b1);
    chk("s5_word", 32'(out_word), 32'h001F);
    chk("s5_err", 32'(out_err), 32'd0);
    push(5'd16, 1'b1);
    chk("s16_word", 32'(out_word), 32'hFFFF);
    chk("s16_err", 32'(out_err), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("s_drain_valid", 32'(out_valid), 32'd0);
    chk("s_drain_count", 32'(count), 32'd0);

    // 3: back-pressure, 9 stalls until the consumer drains
    push(5'd3, 1'b0);
    chk("bp3_word", 32'(out_word), 32'h0007);
    chk("bp3_count", 32'(count), 32'd1);
    push(5'd7, 1'b0);
    chk("bp7_count", 32'(count), 32'd2);
    chk("bp7_ready", 32'(in_ready), 32'd0);
    chk("bp7_word", 32'(out_word), 32'h0007);
    push(5'd15, 1'b0);
    chk("bp_hold_cnt", 32'(count), 32'd2);
    chk("bp_hold_word", 32'(out_word), 32'h0007);
    in_code = 5'd9;
    tick();
    chk("bp9_ready", 32'(in_ready), 32'd0);
    chk("bp9_word", 32'(out_word), 32'h0007);
    out_ready = 1'b1;
    #1;
    chk("bp_through_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_pop1_word", 32'(out_word), 32'h007F);
    chk("bp_pop1_count", 32'(count), 32'd2);
    tick();
    chk("bp_pop2_word", 32'(out_word), 32'h01FF);
    chk("bp_pop2_count", 32'(count), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // 4: push and pop in the same cycle while full
    push(5'd4, 1'b0);
    push(5'd8, 1'b0);
    chk("pp_full", 32'(count), 32'd2);
    in_code   = 5'd12;
    out_ready = 1'b1;
    #1;
    chk("pp_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("pp_count", 32'(count), 32'd2);
    chk("pp_word1", 32'(out_word), 32'h00FF);
    tick();
    chk("pp_word2", 32'(out_word), 32'h0FFF);
    chk("pp_count2", 32'(count), 32'd1);
    tick();
    chk("pp_empty", 32'(count), 32'd0);

    // 5: out-of-range codes saturate and flag err
    push(5'd20, 1'b1);
    chk("oor20_word", 32'(out_word), 32'hFFFF);
    chk("oor20_err", 32'(out_err), 32'd1);
    push(5'd2, 1'b1);
    chk("c2_word", 32'(out_word), 32'h0003);
    chk("c2_err", 32'(out_err), 32'd0);
    push(5'd31, 1'b1);
    chk("oor31_word", 32'(out_word), 32'hFFFF);
    chk("oor31_err", 32'(out_err), 32'd1);
    push(5'd17, 1'b1);
    chk("oor17_err", 32'(out_err), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("oor_empty", 32'(out_valid), 32'd0);

    // 6: reset mid-stream wins over a concurrent push and pop
    push(5'd5, 1'b0);
    push(5'd6, 1'b0);
    chk("mr_full", 32'(count), 32'd2);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_code   = 5'd10;
    out_ready = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);
    chk("mr_word", 32'(out_word), 32'h0000);
    tick();
    chk("mr_still_empty", 32'(out_valid), 32'd0);

    // Round trip: every legal code comes back as that many ones
    for (int c = 0; c <= W; c++) begin
      push(CW'(c), 1'b1);
      exp_word = (c >= W) ? {W{1'b1}} : W'((32'd1 << c) - 32'd1);
      chk("rt_ones", 32'($countones(out_word)), 32'(c));
      chk("rt_word", 32'(out_word), 32'(exp_word));
    end
    in_valid = 1'b0;
    tick();
    chk("rt_empty", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
